// File: rtl/async_fifo_stat_pkg.sv
// async_fifo_stat_pkg: shared helpers for the dual-clock FIFO.
// Gray/binary conversion and a depth helper, width-agnostic.
package async_fifo_stat_pkg;

    localparam int MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Zero upper bits are transparent to both conversions,
    // so any pointer narrower than MAX_PTR_W can be passed in.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_stat_sync.sv
// gray_ptr_sync: multi-flop synchroniser for a Gray-coded pointer.
// Resets asynchronously to zero in the destination domain.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // shift the pointer one stage deeper each edge
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // synchroniser flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_stat.sv
// async_fifo_stat: dual-clock FIFO with Gray pointers, fill counts,
// almost flags, read-valid strobe and sticky overflow/underflow.
module async_fifo_stat
    import async_fifo_stat_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 12,
    parameter int AE_LEVEL    = 2
) (
    input  logic                  write_clk,
    input  logic                  write_reset_n,
    input  logic                  read_clk,
    input  logic                  read_reset_n,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_err_clr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   write_count,
    output logic                  overflow,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic                  read_err_clr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   read_count,
    output logic                  underflow
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] AF_CMP = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CMP = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rgray_sync, rbin_sync;
    logic          overflow_q, overflow_d;
    logic          write_acc;

    gray_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rgray_sync (
        .clk   (write_clk),
        .rst_n (write_reset_n),
        .din   (rgray_q),
        .dout  (rgray_sync)
    );

    assign rbin_sync   = PW'(gray2bin(ptr_word_t'(rgray_sync)));
    assign full        = (wgray_q == {~rgray_sync[PW-1:PW-2],
                                      rgray_sync[PW-3:0]});
    assign write_count = wptr_q - rbin_sync;
    assign almost_full = (write_count >= AF_CMP);
    assign write_acc   = write_en && !full;
    assign overflow    = overflow_q;

    // next write pointer and sticky overflow; set beats clear
    always_comb begin
        wptr_d     = wptr_q;
        wgray_d    = wgray_q;
        overflow_d = overflow_q;
        if (write_acc) begin
            wptr_d  = wptr_q + PW'(1);
            wgray_d = PW'(bin2gray(ptr_word_t'(wptr_d)));
        end
        if (write_err_clr) begin
            overflow_d = 1'b0;
        end
        if (write_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // write-domain state registers
    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            wptr_q     <= '0;
            wgray_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            wgray_q    <= wgray_d;
            overflow_q <= overflow_d;
        end
    end

    // storage write port; contents are deliberately not reset
    always_ff @(posedge write_clk) begin
        if (write_acc) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    // ---------------- read domain ----------------
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic [PW-1:0]         wgray_sync, wbin_sync;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  underflow_q, underflow_d;
    logic                  read_acc;

    gray_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wgray_sync (
        .clk   (read_clk),
        .rst_n (read_reset_n),
        .din   (wgray_q),
        .dout  (wgray_sync)
    );

    assign wbin_sync    = PW'(gray2bin(ptr_word_t'(wgray_sync)));
    assign empty        = (rgray_q == wgray_sync);
    assign read_count   = wbin_sync - rptr_q;
    assign almost_empty = (read_count <= AE_CMP);
    assign read_acc     = read_en && !empty;
    assign read_data    = read_data_q;
    assign read_valid   = read_valid_q;
    assign underflow    = underflow_q;

    // next read pointer, output word and sticky underflow
    always_comb begin
        rptr_d       = rptr_q;
        rgray_d      = rgray_q;
        read_data_d  = read_data_q;
        read_valid_d = read_acc;
        underflow_d  = underflow_q;
        if (read_acc) begin
            read_data_d = mem[rptr_q[ADDR_WIDTH-1:0]];
            rptr_d      = rptr_q + PW'(1);
            rgray_d     = PW'(bin2gray(ptr_word_t'(rptr_d)));
        end
        if (read_err_clr) begin
            underflow_d = 1'b0;
        end
        if (read_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // read-domain state registers
    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            rptr_q       <= '0;
            rgray_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rptr_q       <= rptr_d;
            rgray_q      <= rgray_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_stat.sv
// tb_async_fifo_stat: directed checks of the dual-clock FIFO in
// both clock ratios, including wrap, errors and mid-stream reset.
`timescale 1ns/1ps
module tb_async_fifo_stat;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    always #5 clk_a = ~clk_a;
    always #13.5 clk_b = ~clk_b;

    logic wrst_n = 1'b0;
    logic rrst_n = 1'b0;

    logic       wen0 = 0, wclr0 = 0, ren0 = 0, rclr0 = 0;
    logic [7:0] wdata0 = 0;
    logic       full0, af0, ovf0, rvld0, empty0, ae0, udf0;
    logic [4:0] wcnt0, rcnt0;
    logic [7:0] rdata0;

    logic       wen1 = 0, wclr1 = 0, ren1 = 0, rclr1 = 0;
    logic [7:0] wdata1 = 0;
    logic       full1, af1, ovf1, rvld1, empty1, ae1, udf1;
    logic [4:0] wcnt1, rcnt1;
    logic [7:0] rdata1;

    int total = 0;
    int bad   = 0;

    async_fifo_stat #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2),
        .AF_LEVEL(12), .AE_LEVEL(2)
    ) u0 (
        .write_clk(clk_a), .write_reset_n(wrst_n),
        .read_clk(clk_b), .read_reset_n(rrst_n),
        .write_en(wen0), .write_data(wdata0), .write_err_clr(wclr0),
        .full(full0), .almost_full(af0), .write_count(wcnt0),
        .overflow(ovf0), .read_en(ren0), .read_data(rdata0),
        .read_valid(rvld0), .read_err_clr(rclr0), .empty(empty0),
        .almost_empty(ae0), .read_count(rcnt0), .underflow(udf0)
    );

    async_fifo_stat #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(3),
        .AF_LEVEL(12), .AE_LEVEL(2)
    ) u1 (
        .write_clk(clk_b), .write_reset_n(wrst_n),
        .read_clk(clk_a), .read_reset_n(rrst_n),
        .write_en(wen1), .write_data(wdata1), .write_err_clr(wclr1),
        .full(full1), .almost_full(af1), .write_count(wcnt1),
        .overflow(ovf1), .read_en(ren1), .read_data(rdata1),
        .read_valid(rvld1), .read_err_clr(rclr1), .empty(empty1),
        .almost_empty(ae1), .read_count(rcnt1), .underflow(udf1)
    );

    always @(wrst_n or rrst_n) begin
        #0.1;
        assert (wrst_n === rrst_n)
            else $error("reset domains driven apart");
    end

    task automatic test_reset();
        #2;
        total++;
        if ({full0, af0, ovf0, wcnt0} !== 8'b0) begin
            bad++;
            $display("FAIL reset_wr full=%b af=%b ovf=%b wcnt=%0d want 0",
                     full0, af0, ovf0, wcnt0);
        end
        total++;
        if ({empty0, ae0, rvld0, udf0, rcnt0, rdata0} !== {4'b1100, 13'b0}) begin
            bad++;
            $display("FAIL reset_rd e=%b ae=%b v=%b u=%b cnt=%0d d=%h want 1 1 0 0 0 00",
                     empty0, ae0, rvld0, udf0, rcnt0, rdata0);
        end
        #40;
        wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (3) @(posedge clk_b);
        #0.2;
        total++;
        if (empty0 !== 1'b1 || ae0 !== 1'b1 || rcnt0 !== 5'd0 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle e=%b ae=%b rcnt=%0d full=%b want 1 1 0 0",
                     empty0, ae0, rcnt0, full0);
        end
    endtask

    task automatic test_single();
        int n;
        @(posedge clk_a); #0.2;
        wen0 = 1; wdata0 = 8'hA5;
        @(posedge clk_a); #0.2;
        wen0 = 0;
        n = 0;
        while (empty0 && n < 6) begin
            @(posedge clk_b); #0.2;
            n++;
        end
        total++;
        if (empty0 !== 1'b0 || n > 3) begin
            bad++;
            $display("FAIL single_empty_lat empty=%b edges=%0d want 0 within 3",
                     empty0, n);
        end
        total++;
        if (rcnt0 !== 5'd1 || ae0 !== 1'b1) begin
            bad++;
            $display("FAIL single_rcnt rcnt=%0d ae=%b want 1 1", rcnt0, ae0);
        end
        ren0 = 1;
        @(posedge clk_b); #0.2;
        ren0 = 0;
        total++;
        if (rdata0 !== 8'hA5 || rvld0 !== 1'b1 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL single_read d=%h v=%b e=%b want a5 1 1",
                     rdata0, rvld0, empty0);
        end
        @(posedge clk_b); #0.2;
        total++;
        if (rvld0 !== 1'b0 || rdata0 !== 8'hA5) begin
            bad++;
            $display("FAIL single_hold v=%b d=%h want 0 a5", rvld0, rdata0);
        end
    endtask

    task automatic test_fill();
        repeat (4) @(posedge clk_a);
        #0.2;
        total++;
        if (wcnt0 !== 5'd0 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL fill_start wcnt=%0d full=%b want 0 0", wcnt0, full0);
        end
        wen0 = 1;
        for (int i = 0; i < 16; i++) begin
            wdata0 = i[7:0];
            @(posedge clk_a); #0.2;
            total++;
            if (wcnt0 !== 5'(i + 1)) begin
                bad++;
                $display("FAIL fill_wcnt[%0d] got=%0d want=%0d", i, wcnt0, i + 1);
            end
            total++;
            if (af0 !== (i + 1 >= 12)) begin
                bad++;
                $display("FAIL fill_af[%0d] got=%b want=%b", i, af0, (i + 1 >= 12));
            end
            total++;
            if (full0 !== (i == 15)) begin
                bad++;
                $display("FAIL fill_full[%0d] got=%b want=%b", i, full0, (i == 15));
            end
        end
        wdata0 = 8'hEE;
        @(posedge clk_a); #0.2;
        wen0 = 0;
        total++;
        if (ovf0 !== 1'b1 || full0 !== 1'b1 || wcnt0 !== 5'd16) begin
            bad++;
            $display("FAIL fill_overflow ovf=%b full=%b wcnt=%0d want 1 1 16",
                     ovf0, full0, wcnt0);
        end
        wclr0 = 1;
        @(posedge clk_a); #0.2;
        wclr0 = 0;
        total++;
        if (ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL fill_ovf_clear got=%b want 0", ovf0);
        end
    endtask

    task automatic test_drain();
        repeat (4) @(posedge clk_b);
        #0.2;
        total++;
        if (rcnt0 !== 5'd16 || ae0 !== 1'b0 || empty0 !== 1'b0) begin
            bad++;
            $display("FAIL drain_start rcnt=%0d ae=%b e=%b want 16 0 0",
                     rcnt0, ae0, empty0);
        end
        ren0 = 1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_b); #0.2;
            total++;
            if (rdata0 !== i[7:0] || rvld0 !== 1'b1) begin
                bad++;
                $display("FAIL drain_data[%0d] d=%h v=%b want %h 1",
                         i, rdata0, rvld0, i[7:0]);
            end
            total++;
            if (rcnt0 !== 5'(15 - i) || ae0 !== (15 - i <= 2)) begin
                bad++;
                $display("FAIL drain_cnt[%0d] rcnt=%0d ae=%b want %0d %b",
                         i, rcnt0, ae0, 15 - i, (15 - i <= 2));
            end
        end
        total++;
        if (empty0 !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty got=%b want 1", empty0);
        end
        @(posedge clk_b); #0.2;
        ren0 = 0;
        total++;
        if (udf0 !== 1'b1 || rdata0 !== 8'h0F || rvld0 !== 1'b0) begin
            bad++;
            $display("FAIL drain_underflow u=%b d=%h v=%b want 1 0f 0",
                     udf0, rdata0, rvld0);
        end
        rclr0 = 1;
        @(posedge clk_b); #0.2;
        rclr0 = 0;
        total++;
        if (udf0 !== 1'b0) begin
            bad++;
            $display("FAIL drain_udf_clear got=%b want 0", udf0);
        end
        repeat (4) @(posedge clk_a);
        #0.2;
        total++;
        if (full0 !== 1'b0 || wcnt0 !== 5'd0) begin
            bad++;
            $display("FAIL drain_wside full=%b wcnt=%0d want 0 0", full0, wcnt0);
        end
    endtask

    task automatic test_stream();
        logic [7:0] q[$];
        int sent;
        int got;
        sent = 0;
        got  = 0;
        fork
            begin
                int cyc;
                cyc = 0;
                while (sent < 100 && cyc < 4000) begin
                    @(posedge clk_a); #0.2;
                    cyc++;
                    total++;
                    if (wcnt0 > 5'd16) begin
                        bad++;
                        $display("FAIL stream_wcnt got=%0d want <=16", wcnt0);
                    end
                    wen0 = 0;
                    if (!full0 && ($urandom % 4 != 0)) begin
                        wen0   = 1;
                        wdata0 = 8'(sent * 37 + 11);
                        q.push_back(wdata0);
                        sent++;
                    end
                end
                @(posedge clk_a); #0.2;
                wen0 = 0;
            end
            begin
                int  cyc;
                bit  pend;
                logic [7:0] exp;
                cyc  = 0;
                pend = 0;
                while (got < 100 && cyc < 8000) begin
                    @(posedge clk_b); #0.2;
                    cyc++;
                    total++;
                    if (rvld0 !== pend) begin
                        bad++;
                        $display("FAIL stream_valid got=%b want=%b", rvld0, pend);
                    end
                    if (pend) begin
                        got++;
                        total++;
                        if (q.size() == 0) begin
                            bad++;
                            $display("FAIL stream_extra d=%h want none", rdata0);
                        end else begin
                            exp = q.pop_front();
                            if (rdata0 !== exp) begin
                                bad++;
                                $display("FAIL stream_data[%0d] got=%h want=%h",
                                         got - 1, rdata0, exp);
                            end
                        end
                    end
                    pend = 0;
                    ren0 = 0;
                    if (got < 100 && !empty0 && ($urandom % 3 != 0)) begin
                        ren0 = 1;
                        pend = 1;
                    end
                end
                ren0 = 0;
            end
        join
        total++;
        if (sent != 100 || got != 100) begin
            bad++;
            $display("FAIL stream_count sent=%0d got=%0d want 100 100", sent, got);
        end
        total++;
        if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin
            bad++;
            $display("FAIL stream_errors ovf=%b udf=%b want 0 0", ovf0, udf0);
        end
    endtask

    task automatic test_swapped();
        int n;
        logic [7:0] exp;
        @(posedge clk_b); #0.2;
        wen1 = 1; wdata1 = 8'h5A;
        @(posedge clk_b); #0.2;
        wen1 = 0;
        n = 0;
        while (empty1 && n < 8) begin
            @(posedge clk_a); #0.2;
            n++;
        end
        total++;
        if (empty1 !== 1'b0 || n > 4) begin
            bad++;
            $display("FAIL swap_empty_lat empty=%b edges=%0d want 0 within 4",
                     empty1, n);
        end
        wen1 = 1;
        for (int i = 0; i < 4; i++) begin
            wdata1 = 8'(8'h10 + i);
            @(posedge clk_b); #0.2;
        end
        wen1 = 0;
        total++;
        if (wcnt1 !== 5'd5) begin
            bad++;
            $display("FAIL swap_wcnt got=%0d want 5", wcnt1);
        end
        repeat (5) @(posedge clk_a);
        #0.2;
        total++;
        if (rcnt1 !== 5'd5) begin
            bad++;
            $display("FAIL swap_rcnt got=%0d want 5", rcnt1);
        end
        ren1 = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_a); #0.2;
            exp = (i == 0) ? 8'h5A : 8'(8'h10 + i - 1);
            total++;
            if (rdata1 !== exp || rvld1 !== 1'b1) begin
                bad++;
                $display("FAIL swap_data[%0d] d=%h v=%b want %h 1",
                         i, rdata1, rvld1, exp);
            end
        end
        ren1 = 0;
        total++;
        if (empty1 !== 1'b1 || udf1 !== 1'b0 || ovf1 !== 1'b0) begin
            bad++;
            $display("FAIL swap_end e=%b u=%b o=%b want 1 0 0",
                     empty1, udf1, ovf1);
        end
    endtask

    task automatic test_midreset();
        int n;
        @(posedge clk_a); #0.2;
        wen0 = 1;
        for (int i = 0; i < 7; i++) begin
            wdata0 = 8'(8'h40 + i);
            @(posedge clk_a); #0.2;
        end
        wen0 = 0;
        repeat (4) @(posedge clk_b);
        #0.2;
        total++;
        if (rcnt0 !== 5'd7 || wcnt0 !== 5'd7) begin
            bad++;
            $display("FAIL midrst_pre rcnt=%0d wcnt=%0d want 7 7", rcnt0, wcnt0);
        end
        #3;
        wrst_n = 1'b0; rrst_n = 1'b0;
        @(posedge clk_a);
        @(posedge clk_b);
        #0.2;
        total++;
        if ({full0, af0, ovf0, wcnt0} !== 8'b0) begin
            bad++;
            $display("FAIL midrst_wr full=%b af=%b ovf=%b wcnt=%0d want 0",
                     full0, af0, ovf0, wcnt0);
        end
        total++;
        if ({empty0, ae0, rvld0, udf0, rcnt0, rdata0} !== {4'b1100, 13'b0}) begin
            bad++;
            $display("FAIL midrst_rd e=%b ae=%b v=%b u=%b cnt=%0d d=%h want 1 1 0 0 0 00",
                     empty0, ae0, rvld0, udf0, rcnt0, rdata0);
        end
        #3;
        wrst_n = 1'b1; rrst_n = 1'b1;
        @(posedge clk_a); #0.2;
        wen0 = 1; wdata0 = 8'h3C;
        @(posedge clk_a); #0.2;
        wen0 = 0;
        n = 0;
        while (empty0 && n < 6) begin
            @(posedge clk_b); #0.2;
            n++;
        end
        total++;
        if (empty0 !== 1'b0 || rcnt0 !== 5'd1) begin
            bad++;
            $display("FAIL midrst_arrive e=%b rcnt=%0d want 0 1", empty0, rcnt0);
        end
        ren0 = 1;
        @(posedge clk_b); #0.2;
        ren0 = 0;
        total++;
        if (rdata0 !== 8'h3C || rvld0 !== 1'b1 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL midrst_read d=%h v=%b e=%b want 3c 1 1",
                     rdata0, rvld0, empty0);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_stream();
        test_swapped();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
